// File: rtl/immgen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry elastic output buffer.
// Optional AES byte-select decode (custom-0 opcode) enabled by `define IMMGEN_AES_BS_EN.
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_AES = 3'd6;
    localparam logic [2:0] FMT_UNK = 3'd7;

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [XLEN-1:0]    out_imm_q;
    logic [2:0]         out_fmt_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic [XLEN-1:0]    skid_imm_q;
    logic [2:0]         skid_fmt_q;
    logic [TAG_W-1:0]   skid_tag_q;

    logic [31:0]        imm32_d;
    logic [XLEN-1:0]    imm_d;
    logic [2:0]         fmt_d;
    logic               sgn;
    logic               accept;

    // Every format fits in 32 bits with its sign at bit 31, so widening is one replication.
    always_comb begin
        sgn     = in_instr[31];
        imm32_d = '0;
        fmt_d   = FMT_UNK;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111, 7'b0011011: begin
                fmt_d   = FMT_I;
                imm32_d = {{20{sgn}}, in_instr[31:20]};
            end
            7'b0100011: begin
                fmt_d   = FMT_S;
                imm32_d = {{20{sgn}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                fmt_d   = FMT_B;
                imm32_d = {{19{sgn}}, sgn, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt_d   = FMT_U;
                imm32_d = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt_d   = FMT_J;
                imm32_d = {{11{sgn}}, sgn, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: begin
                fmt_d   = FMT_R;
                imm32_d = '0;
            end
`ifdef IMMGEN_AES_BS_EN
            7'b0001011: begin
                fmt_d   = FMT_AES;
                imm32_d = {30'b0, in_instr[31:30]};
            end
`else
            7'b0001011: begin
                fmt_d   = FMT_UNK;
                imm32_d = '0;
            end
`endif
            default: begin
                fmt_d   = FMT_UNK;
                imm32_d = '0;
            end
        endcase
    end

    assign imm_d  = {{(XLEN-31){imm32_d[31]}}, imm32_d[30:0]};
    assign accept = in_valid && in_ready_q;

    // Occupancy FSM; in_ready is registered from the next state so no comb path reaches upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_fmt_q   <= '0;
            out_tag_q   <= '0;
            skid_imm_q  <= '0;
            skid_fmt_q  <= '0;
            skid_tag_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_imm_q   <= imm_d;
                        out_fmt_q   <= fmt_d;
                        out_tag_q   <= in_tag;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (out_ready) begin
                        if (accept) begin
                            out_imm_q <= imm_d;
                            out_fmt_q <= fmt_d;
                            out_tag_q <= in_tag;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= EMPTY;
                        end
                    end else if (accept) begin
                        skid_imm_q <= imm_d;
                        skid_fmt_q <= fmt_d;
                        skid_tag_q <= in_tag;
                        in_ready_q <= 1'b0;
                        state_q    <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_imm_q  <= skid_imm_q;
                        out_fmt_q  <= skid_fmt_q;
                        out_tag_q  <= skid_tag_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_fmt   = out_fmt_q;
    assign out_tag   = out_tag_q;
    assign occ       = state_q;

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage of the RISC-V core, including the AES custom extension.
- Accepts one 32-bit instruction per cycle on a valid/ready stream and classifies its format from the opcode.
- Emits a single XLEN-wide sign-extended immediate, a format code and a pass-through tag.
- A 2-entry elastic buffer (output register plus skid register) sustains full throughput under backpressure without a combinational ready path.

Parameters:
XLEN, 32, datapath width of out_imm; legal values are 32 and 64.
TAG_W, 4, width of the opaque tag carried alongside each instruction.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept; driven from a register only
in_instr  input  32  raw instruction word
in_tag  input  TAG_W  opaque tag, returned unchanged
out_valid  output  1  out_* fields hold a valid result
out_ready  input  1  downstream accepts the result
out_imm  output  XLEN  decoded immediate
out_fmt  output  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=AES-bs, 7=unknown
out_tag  output  TAG_W  tag of the instruction in out_*
occ  output  2  entries held: 0, 1 or 2

Behaviour:
- Transfer rule: a transfer occurs when valid and ready are both high in the same cycle, on either side.
- Latency: one cycle. A beat accepted at edge N is visible on out_* after edge N when the output register is free.
- Format decode on opcode in_instr[6:0]:
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - 0110011, 0111011 -> R, imm 0
  - 0011011 -> I
  - 0001011 -> see Optional Feature
  - anything else -> 7, imm 0
- Immediate construction:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - Every format is sign-extended from instr[31] to XLEN bits. For XLEN=64 this includes U.
- Immediate computation happens before registration. Both the output register and the skid register store the computed imm/fmt/tag, never the raw instr.
- Occupancy states:
  - EMPTY (occ 0): in_ready=1. An input beat loads the output register -> ONE.
  - ONE (occ 1):
    - out_ready=1 with input beat: output reloaded, stay ONE.
    - out_ready=1, no input: -> EMPTY.
    - out_ready=0 with input beat: beat goes to skid -> FULL.
    - out_ready=0, no input: hold.
  - FULL (occ 2): in_ready=0. On out_ready=1 the skid moves to the output register -> ONE. Input is ignored in this state.
- in_ready equals the registered !(state==FULL).
- Order: strict FIFO order is preserved, and no beat is dropped or duplicated.
- out_* stability: out_* holds stable while out_valid=1 and out_ready=0.
- Reset values (rst=1):
  - state -> EMPTY, occ=0
  - out_valid=0, in_ready=1 in the cycle after reset
  - out_imm=0, out_fmt=0, out_tag=0
  - skid contents cleared
- Reset mid-operation: any held beats are discarded. An input handshake in the reset cycle is not accepted.
- X-safety: out_imm, out_fmt and out_tag change only on a load; they are not updated when no transfer occurs.

Optional Feature:
IMMGEN_AES_BS_EN:
- Defined: opcode 0001011 (custom-0, AES ops) decodes to fmt 6. out_imm = zero-extended instr[31:30] (byte select), range 0..3.
- Undefined: opcode 0001011 yields fmt 7, imm 0.

Test Plan:
1. XLEN=32, in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_fmt=1, tag echoed.
2. Back-to-back 0xFE112E23, 0xFE000CE3, 0x0000006F -> three consecutive outputs with no bubbles:
   - imm 0xFFFFFFFC fmt 2
   - imm 0xFFFFFFF8 fmt 3
   - imm 0 fmt 5
3. XLEN=64, in 0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000, fmt 4; in 0x00000033 -> imm 0, fmt 0.
4. Backpressure: stream tags 1,2,3 with out_ready=0 for 4 cycles.
   - Expect occ to reach 2 and in_ready=0; tag 3 is held upstream.
   - Then raise out_ready and expect tags 1,2,3 in order, each once.
5. With occ=2, assert rst for one cycle -> next cycle out_valid=0, occ=0, in_ready=1; a following 0xFFF00093 gives imm 0xFFFFFFFF.
6. in 0xC000000B: with IMMGEN_AES_BS_EN -> fmt 6, imm 3; without -> fmt 7, imm 0.
